// File: rtl/ex_mem_stage.sv
// EX stage of a 5-stage MIPS-style pipeline: ALU, branch target, destination select,
// and a 32-iteration shift-add signed multiplier that stalls upstream and writes HI/LO.
module ex_mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [143:0] id_ex_bundle,
  output logic         stall,
  output logic [106:0] ex_mem_bundle,
  output logic [31:0]  hi_out,
  output logic [31:0]  lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic        [4:0]   r_cnt;
  logic        [106:0] r_ex_mem, w_ex_mem_nxt;
  logic        [31:0]  r_hi, r_lo;
  logic        [63:0]  r_mcand, r_prod;
  logic        [31:0]  r_mplier;
  logic                r_neg;
  logic                w_capture, w_hilo_load, w_is_mult;

  logic        [1:0]   w_wb;
  logic        [2:0]   w_m;
  logic                w_regdst, w_alusrc;
  logic        [1:0]   w_aluop;
  logic        [31:0]  w_npc, w_imm, w_bt, w_alu;
  logic signed [31:0]  w_rd1, w_rd2, w_op_a, w_op_b;
  logic        [4:0]   w_rt, w_dest;
  logic        [5:0]   w_funct;
  logic                w_unused_rsvd;
  logic        [63:0]  w_product;

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    mag32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] sign_fix(input logic [63:0] p, input logic neg);
    sign_fix = neg ? (~p + 64'd1) : p;
  endfunction

  assign w_wb          = id_ex_bundle[143:142];
  assign w_m           = id_ex_bundle[141:139];
  assign w_regdst      = id_ex_bundle[138];
  assign w_aluop       = id_ex_bundle[137:136];
  assign w_alusrc      = id_ex_bundle[135];
  assign w_npc         = id_ex_bundle[134:103];
  assign w_rd1         = id_ex_bundle[102:71];
  assign w_rd2         = id_ex_bundle[70:39];
  assign w_imm         = id_ex_bundle[38:7];
  assign w_rt          = id_ex_bundle[6:2];
  assign w_unused_rsvd = ^id_ex_bundle[1:0];
  assign w_funct       = w_imm[5:0];

  assign w_op_a = w_rd1;
  assign w_op_b = w_alusrc ? signed'(w_imm) : w_rd2;
  assign w_dest = w_regdst ? w_imm[15:11] : w_rt;
  assign w_bt   = w_npc + {w_imm[29:0], 2'b00};

  always_comb begin
    w_alu     = '0;
    w_is_mult = 1'b0;
    case (w_aluop)
      2'b00: w_alu = w_op_a + w_op_b;
      2'b01: w_alu = w_op_a - w_op_b;
      2'b11: w_alu = {31'd0, (w_op_a < w_op_b)};
      default: begin
        case (w_funct)
          6'h20:   w_alu = w_op_a + w_op_b;
          6'h22:   w_alu = w_op_a - w_op_b;
          6'h24:   w_alu = w_op_a & w_op_b;
          6'h25:   w_alu = w_op_a | w_op_b;
          6'h2A:   w_alu = {31'd0, (w_op_a < w_op_b)};
          6'h10:   w_alu = r_hi;
          6'h12:   w_alu = r_lo;
          6'h18:   w_is_mult = 1'b1;
          default: w_alu = '0;
        endcase
      end
    endcase
  end

  assign w_product = sign_fix(r_prod, r_neg);

  // Control: multiply sequencing, stall and next ex_mem contents
  always_comb begin
    w_state_nxt  = r_state;
    stall        = 1'b0;
    w_capture    = 1'b0;
    w_hilo_load  = 1'b0;
    w_ex_mem_nxt = {w_wb, w_m, w_bt, (w_alu == 32'd0), w_alu, w_rd2, w_dest};
    case (r_state)
      S_IDLE: begin
        if (w_is_mult) begin
          stall        = 1'b1;
          w_capture    = 1'b1;
          w_ex_mem_nxt = '0;
          w_state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        stall        = 1'b1;
        w_ex_mem_nxt = '0;
        if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_hilo_load  = 1'b1;
        w_ex_mem_nxt = {2'b00, 3'b000, w_bt, 1'b1, 32'd0, w_rd2, 5'd0};
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ex_mem <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ex_mem <= w_ex_mem_nxt;
      if (w_capture)              r_cnt <= '0;
      else if (r_state == S_BUSY) r_cnt <= r_cnt + 5'd1;
      if (w_hilo_load) {r_hi, r_lo} <= w_product;
    end
  end

  // Multiplier datapath works on magnitudes; sign is restored when HI/LO load
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mcand  <= {32'd0, mag32(w_rd1)};
      r_mplier <= mag32(w_rd2);
      r_prod   <= '0;
      r_neg    <= w_rd1[31] ^ w_rd2[31];
    end else if (r_state == S_BUSY) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign ex_mem_bundle = r_ex_mem;
  assign hi_out        = r_hi;
  assign lo_out        = r_lo;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of single-cycle ALU vectors plus
// hand-written multiply, reset-abort and back-to-back sequences.
module tb_ex_mem_stage;

  logic         clk;
  logic         reset;
  logic [143:0] id_ex_bundle;
  logic         stall;
  logic [106:0] ex_mem_bundle;
  logic [31:0]  hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .id_ex_bundle(id_ex_bundle), .stall(stall),
    .ex_mem_bundle(ex_mem_bundle), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [143:0] in;
    logic [106:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [143:0] mk(input logic [1:0] wb, input logic [2:0] m,
      input logic [3:0] ex, input logic [31:0] npc, input logic [31:0] rd1,
      input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rt);
    mk = {wb, m, ex, npc, rd1, rd2, imm, rt, 2'b00};
  endfunction

  function automatic logic [106:0] pk(input logic [1:0] wb, input logic [2:0] m,
      input logic [31:0] bt, input logic z, input logic [31:0] alu,
      input logic [31:0] rd2, input logic [4:0] dest);
    pk = {wb, m, bt, z, alu, rd2, dest};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, output int n);
    logic ok;
    id_ex_bundle = mk(2'b10, 3'b000, 4'b1100, 32'h0, a, b, 32'h18, 5'd0);
    #1;
    chk("mult_stall_on_issue", {127'd0, stall}, 128'd1);
    n  = 0;
    ok = 1'b1;
    while (stall && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (stall && ex_mem_bundle !== 107'd0) ok = 1'b0;
      // upstream garbage on operands while busy must not affect the product
      id_ex_bundle[102:39] = {$urandom, $urandom};
    end
    chk("mult_bubbles", {127'd0, ok}, 128'd1);
    if (n >= 100) chk("mult_timeout", 128'(n), 128'd33);
    @(posedge clk);
    @(negedge clk);
    chk("mult_entry", {ex_mem_bundle[106:102], ex_mem_bundle[68:37], ex_mem_bundle[4:0]}, 128'd0);
  endtask

  initial begin
    int n1, n2;
    tbl[0]  = '{mk(2'b10,3'b000,4'b1100,32'h400,32'h7FFFFFFF,32'h1,32'h2820,5'd0),
                pk(2'b10,3'b000,32'h0000A480,1'b0,32'h80000000,32'h1,5'd5)};
    tbl[1]  = '{mk(2'b00,3'b100,4'b0010,32'h100,32'h1234,32'h1234,32'hFFFFFFFF,5'd0),
                pk(2'b00,3'b100,32'h000000FC,1'b1,32'h0,32'h1234,5'd0)};
    tbl[2]  = '{mk(2'b10,3'b000,4'b0110,32'h0,32'hFFFFFFFF,32'h0,32'h0,5'd3),
                pk(2'b10,3'b000,32'h0,1'b0,32'h1,32'h0,5'd3)};
    tbl[3]  = '{mk(2'b11,3'b010,4'b0001,32'h200,32'h1000,32'hDEAD,32'h10,5'd9),
                pk(2'b11,3'b010,32'h240,1'b0,32'h1010,32'hDEAD,5'd9)};
    tbl[4]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'h5,32'h7,32'h1822,5'd0),
                pk(2'b10,3'b000,32'h6088,1'b0,32'hFFFFFFFE,32'h7,5'd3)};
    tbl[5]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'hF0F0F0F0,32'hFF00FF00,32'h2024,5'd0),
                pk(2'b10,3'b000,32'h8090,1'b0,32'hF000F000,32'hFF00FF00,5'd4)};
    tbl[6]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'hF0F0F0F0,32'h0F0F0F0F,32'h2025,5'd0),
                pk(2'b10,3'b000,32'h8094,1'b0,32'hFFFFFFFF,32'h0F0F0F0F,5'd4)};
    tbl[7]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'h1,32'hFFFFFFFF,32'h202A,5'd0),
                pk(2'b10,3'b000,32'h80A8,1'b1,32'h0,32'hFFFFFFFF,5'd4)};
    tbl[8]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'h1,32'h2,32'h203F,5'd0),
                pk(2'b10,3'b000,32'h80FC,1'b1,32'h0,32'h2,5'd4)};
    tbl[9]  = '{mk(2'b10,3'b000,4'b1100,32'h0,32'h9,32'h8,32'h2010,5'd0),
                pk(2'b10,3'b000,32'h8040,1'b1,32'h0,32'h8,5'd4)};
    tbl[10] = '{mk(2'b01,3'b001,4'b0000,32'h10,32'hFFFFFFFF,32'h1,32'h0,5'd7),
                pk(2'b01,3'b001,32'h10,1'b1,32'h0,32'h1,5'd7)};
    tbl[11] = '{mk(2'b10,3'b010,4'b0001,32'h1000,32'h100,32'h5,32'hFFFFFFF0,5'd2),
                pk(2'b10,3'b010,32'hFC0,1'b0,32'hF0,32'h5,5'd2)};

    reset = 1'b0;
    id_ex_bundle = '0;
    repeat (3) @(negedge clk);
    chk("reset_bundle", 128'(ex_mem_bundle), 128'd0);
    chk("reset_hilo", {64'd0, hi_out, lo_out}, 128'd0);
    chk("reset_stall", {127'd0, stall}, 128'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      id_ex_bundle = tbl[i].in;
      #1;
      chk($sformatf("vec%0d_stall", i), {127'd0, stall}, 128'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_bundle", i), 128'(ex_mem_bundle), 128'(tbl[i].exp));
    end

    // reset during a multiply at counter=10
    id_ex_bundle = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h1234, 32'h10, 32'h18, 5'd0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_bundle", 128'(ex_mem_bundle), 128'd0);
    chk("abort_stall_follows_input", {127'd0, stall}, 128'd1);
    id_ex_bundle = '0;
    #1;
    chk("abort_stall_nop", {127'd0, stall}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_bundle_held", 128'(ex_mem_bundle), 128'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_hilo", {64'd0, hi_out, lo_out}, 128'd0);

    do_mult(32'd5, 32'd7, n1);
    chk("m5x7_stalls", 128'(n1), 128'd33);
    chk("m5x7_hilo", {64'd0, hi_out, lo_out}, {64'd0, 32'd0, 32'd35});

    do_mult(32'hFFFFFFFE, 32'd3, n1);
    chk("mneg_stalls", 128'(n1), 128'd33);
    chk("mneg_hilo", {64'd0, hi_out, lo_out}, {64'd0, 32'hFFFFFFFF, 32'hFFFFFFFA});
    id_ex_bundle = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h1012, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mneg_mflo", 128'(ex_mem_bundle[68:37]), 128'hFFFFFFFA);

    do_mult(32'd2, 32'd3, n1);
    chk("b2b_first_lo", 128'(lo_out), 128'd6);
    do_mult(32'd4, 32'd5, n2);
    chk("b2b_total_stalls", 128'(n1 + n2), 128'd66);
    chk("b2b_hilo", {64'd0, hi_out, lo_out}, {64'd0, 32'd0, 32'd20});
    id_ex_bundle = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h1010, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_mfhi", 128'(ex_mem_bundle[68:37]), 128'd0);
    id_ex_bundle = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h1012, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_mflo", 128'(ex_mem_bundle[68:37]), 128'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_ex_bundle  input  144  registered ID/EX bundle: [143:142] wb{regwrite,memtoreg}, [141:139] m{branch,memread,memwrite}, [138:135] ex{regdst,aluop[1:0],alusrc}, [134:103] npc, [102:71] rd1, [70:39] rd2, [38:7] imm (sign-extended), [6:2] rt, [1:0] reserved (ignored).
REQ-005 stall  output  1  combinational; when high, upstream SHALL hold id_ex_bundle unchanged.
REQ-006 ex_mem_bundle  output  107  registered: [106:105] wb, [104:102] m, [101:70] branch_target, [69] zero, [68:37] alu_result, [36:5] rd2, [4:0] dest_reg.
REQ-007 hi_out, lo_out  output  32 each  current HI/LO registers.

Function
REQ-008 dest_reg SHALL be imm[15:11] when regdst=1, else rt.
REQ-009 ALU operand B SHALL be imm when alusrc=1, else rd2; operand A is always rd1.
REQ-010 aluop 00 SHALL add; 01 SHALL subtract; 11 SHALL signed set-less-than; 10 SHALL decode funct=imm[5:0].
REQ-011 funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x10 mfhi (result=HI), 0x12 mflo (result=LO), 0x18 MULT; any other funct gives result 0.
REQ-012 add/sub SHALL wrap modulo 2^32 with no overflow indication; slt result SHALL be 32'd1 or 32'd0.
REQ-013 branch_target SHALL be npc + (imm << 2), modulo 2^32; zero SHALL be 1 iff alu_result==0.
REQ-014 In non-MULT cycles ex_mem_bundle SHALL load every edge (latency 1 cycle); wb, m, rd2 pass through unchanged.
REQ-015 Multiplier FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE with MULT decoded: capture rd1, rd2 (signed), clear 5-bit counter, go BUSY; ex_mem_bundle loads all-zero bubble.
REQ-017 BUSY: one shift-add iteration per cycle on magnitudes; after the 32nd iteration go DONE; ex_mem_bundle loads bubble every BUSY cycle.
REQ-018 DONE: apply sign correction, load {HI,LO} with the 64-bit signed product, emit MULT entry with wb forced 00, m forced 000, dest_reg 0, alu_result 0; go IDLE.
REQ-019 stall SHALL equal (IDLE and MULT decoded) or BUSY; low in DONE so upstream advances on the DONE edge.
REQ-020 MULT occupancy SHALL be 34 cycles from capture edge to the edge the next instruction is captured.
REQ-021 id_ex_bundle changes while BUSY SHALL be ignored; operands come only from captured copies.
REQ-022 mfhi/mflo in the cycle after DONE SHALL read the new HI/LO.
REQ-023 Back-to-back MULTs: second MULT SHALL be captured in the IDLE cycle after DONE, with no lost cycle beyond REQ-020.

Reset
REQ-024 reset low SHALL asynchronously force ex_mem_bundle=0, HI=0, LO=0, counter=0, state IDLE; stall then depends only on id_ex_bundle.
REQ-025 reset mid-MULT SHALL abort the multiply; HI/LO SHALL not be updated.
REQ-026 After reset release, first rising edge SHALL process id_ex_bundle normally.

Verification
REQ-027 R-type add, rd1=0x7FFFFFFF, rd2=1, regdst=1, imm[15:11]=5 -> next edge alu_result=0x80000000, zero=0, dest_reg=5.
REQ-028 beq-style aluop=01, rd1=rd2=0x1234, npc=0x100, imm=0xFFFFFFFF -> zero=1, branch_target=0x000000FC.
REQ-029 slt with rd1=0xFFFFFFFF, rd2=0 -> alu_result=1; lw-style aluop=00, alusrc=1, rd1=0x1000, imm=0x10, rt=9 -> alu_result=0x1010, dest_reg=9.
REQ-030 MULT rd1=0xFFFFFFFE (-2), rd2=3 -> stall high 33 cycles, bubbles emitted, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; following mflo -> alu_result=0xFFFFFFFA.
REQ-031 Assert reset at BUSY counter=10 -> outputs 0, state IDLE, HI/LO stay 0; re-issued MULT 5x7 completes with LO=35, HI=0.
REQ-032 Two back-to-back MULTs 2x3 then 4x5 with mfhi/mflo after -> LO=20, HI=0, total stall cycles 66.
